alu_mdu: RTL
============

Name: alu_mdu

Overview:
- Parametrised successor of the single-cycle integer ALU: executes all base ALU operations plus the RV32M multiply/divide group.
- Base ops complete in one registered cycle. MUL*/DIV*/REM* run on an iterative radix-2 datapath.
- Sits in the execute stage behind the decoder. A valid/ready handshake on both sides lets the pipeline stall while a long op is in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width (even, ≥8)
- OPCODE_LENGTH, 5, Operation width; codes 0x00-0x0F are the base ALU set, 0x10-0x17 are M-extension
- IMM_WIDTH, 12, width of the immediate field sign-extended when isImmediate=1

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid & in_ready
- Operation  in  OPCODE_LENGTH  operation code
- SrcA  in  DATA_WIDTH  operand A
- SrcB  in  DATA_WIDTH  operand B or immediate
- isImmediate  in  1  use sign-extended SrcB[IMM_WIDTH-1:0] as B
- flush  in  1  abandon any in-flight or pending op
- out_valid  out  1  ALUResult valid
- out_ready  in  1  consumer takes result when out_valid & out_ready
- ALUResult  out  DATA_WIDTH  registered result
- busy  out  1  iterative op in progress

Behaviour:

Reset:
- Reset asserted: state=IDLE, out_valid=0, ALUResult=0, busy=0, internal accumulators=0.
- in_ready=1 once rst_n is released.

Operand capture:
- B = isImmediate ? sext(SrcB[IMM_WIDTH-1:0]) : SrcB.
- Operands are captured at acceptance. Input ports are don't-care afterwards.

Opcode map:
- 0x00 AND, 0x01 OR, 0x02 XOR, 0x03 ADD, 0x04 SUB, 0x05 SRL, 0x06 SRA, 0x07 SLL
- 0x08 EQ, 0x09 NE, 0x0A SLT, 0x0B SGE (signed), 0x0C pass A, 0x0D pass B, 0x0E SLTU, 0x0F SGEU
- 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU
- 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU
- Any other code completes as a base op with result 0.

Arithmetic rules:
- Shifts use only B[$clog2(DATA_WIDTH)-1:0]. This is a decided change from the old full-B shift.
- Add/sub wrap modulo 2^DATA_WIDTH.
- Compare results are zero-extended 1/0.
- MUL returns the low half of the 2*DATA_WIDTH product. MULH/MULHSU/MULHU return the high half with ss/su/uu signedness.
- DIV/REM truncate toward zero. Remainder takes the sign of the dividend.

Divide special cases (fast path, one cycle like base ops):
- Divide by zero: DIV/DIVU return all-ones; REM/REMU return A.
- Signed overflow (A=most-negative, B=-1): DIV returns A; REM returns 0.

FSM states IDLE, BUSY, DONE:
- IDLE: in_ready=1. On accept of a base op or divide special case, compute, register ALUResult, go to DONE. On accept of a normal mul/div, load magnitudes and sign flags, counter=DATA_WIDTH, go to BUSY.
- BUSY: in_ready=0, busy=1. One shift-add or restoring-subtract iteration per cycle. When counter reaches 0, apply sign correction, register the result, go to DONE.
- DONE: out_valid=1, ALUResult held stable until out_ready.
  - out_ready & !in_valid goes to IDLE.
  - out_ready & in_valid accepts the next op in the same cycle, so in_ready = (state==IDLE) | (state==DONE & out_ready).
  - This gives back-to-back base ops at one result per cycle.

Latency (from acceptance edge to first cycle out_valid=1):
- Base ops and special cases: 1 cycle.
- Normal mul/div: DATA_WIDTH+1 cycles.

Flush and reset mid-op:
- flush=1 from any state goes to IDLE next edge, with out_valid=0 and busy=0. ALUResult keeps its last value.
- No op is accepted in the cycle flush=1 (in_ready forced 0).
- flush beats simultaneous in_valid and out_ready.
- rst_n low mid-op aborts immediately and asynchronously to the reset values.

Decomposition:
- Package alu_mdu_pkg:
  - enum alu_op_e listing all 24 codes
  - enum state_e {IDLE, BUSY, DONE}
  - helper is_muldiv(op)
- One sub-module: alu_mdu_iter, the iterative mul/div datapath.
  - Holds its own counter, accumulator and sign-fix logic.
  - start/done interface; done pulses for one cycle.
- The base-op combinational case stays in the top level.

Test Plan (DATA_WIDTH=32):
- Reset check: hold rst_n=0 with in_valid=1, then release → out_valid=0, ALUResult=0, busy=0, in_ready=1 on the first cycle after release.
- ADDI with SrcA=5, SrcB=0x00000FFF, isImmediate=1, out_ready=1 → out_valid the next cycle, ALUResult=4. Then issue SRL with A=0x80000000, B=0x21 → result 0x40000000 (shift by 1 only).
- MULH A=0x80000000, B=0x80000000 → busy for 32 cycles, out_valid at cycle 33, ALUResult=0x40000000. MUL on the same operands → 0x00000000.
- DIV A=-7, B=2 → 0xFFFFFFFD. REM A=-7, B=2 → 0xFFFFFFFF. DIVU A=7, B=0 → 0xFFFFFFFF in 1 cycle. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000 in 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after a DONE → ALUResult stable, in_ready=0. Raise out_ready together with a new valid ADD → both transfers happen in the same cycle.
- Flush at cycle 10 of a DIVU → out_valid never asserts for it, busy drops next cycle. A following AND 0xF0 & 0x3C → 0x30 with 1-cycle latency.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared types for the ALU + RV32M execute unit: opcode map, FSM states, helpers.
package alu_mdu_pkg;

  localparam int unsigned CODE_WIDTH = 5;

  typedef enum logic [CODE_WIDTH-1:0] {
    OP_AND    = 5'h00, OP_OR     = 5'h01, OP_XOR    = 5'h02, OP_ADD    = 5'h03,
    OP_SUB    = 5'h04, OP_SRL    = 5'h05, OP_SRA    = 5'h06, OP_SLL    = 5'h07,
    OP_EQ     = 5'h08, OP_NE     = 5'h09, OP_SLT    = 5'h0A, OP_SGE    = 5'h0B,
    OP_PASSA  = 5'h0C, OP_PASSB  = 5'h0D, OP_SLTU   = 5'h0E, OP_SGEU   = 5'h0F,
    OP_MUL    = 5'h10, OP_MULH   = 5'h11, OP_MULHSU = 5'h12, OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14, OP_DIVU   = 5'h15, OP_REM    = 5'h16, OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic is_muldiv(input logic [CODE_WIDTH-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Decoder-to-execute handshake bundle for alu_mdu.
interface alu_mdu_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic                     isImmediate;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     busy;

  modport master (
    output in_valid, Operation, SrcA, SrcB, isImmediate, flush, out_ready,
    input  in_ready, out_valid, ALUResult, busy
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, isImmediate, flush, out_ready,
    output in_ready, out_valid, ALUResult, busy
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative radix-2 multiply (shift-add) / restoring divide on magnitudes with final sign fix.
module alu_mdu_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  start,
  input  logic [2:0]            func,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done_c,
  output logic [DATA_WIDTH-1:0] result_c
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic          active, is_div, sel_hi, neg_q, neg_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, lo, m, hi_n, lo_n, a_mag, b_mag, q_fix, r_fix;
  logic          a_sgn, b_sgn, a_neg, b_neg;
  logic [W:0]    sum, rsh, diff;
  logic [2*W-1:0] prod_fix;

  // Operand signedness per function: MULH/DIV/REM ss, MULHSU su, the rest uu.
  always_comb begin
    a_sgn = (func == 3'd1) | (func == 3'd2) | (func == 3'd4) | (func == 3'd6);
    b_sgn = (func == 3'd1) | (func == 3'd4) | (func == 3'd6);
    a_neg = a_sgn & a[W-1];
    b_neg = b_sgn & b[W-1];
    a_mag = a_neg ? W'(-a) : a;
    b_mag = b_neg ? W'(-b) : b;
  end

  // hi holds partial product / partial remainder, lo holds multiplier / quotient bits.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(W+1){1'b0}});
    rsh  = {hi, lo[W-1]};
    diff = rsh - {1'b0, m};
    if (is_div) begin
      if (!diff[W]) begin
        hi_n = diff[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = rsh[W-1:0];
        lo_n = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[W:1];
      lo_n = {sum[0], lo[W-1:1]};
    end
    prod_fix = neg_q ? (2*W)'(-{hi_n, lo_n}) : {hi_n, lo_n};
    q_fix    = neg_q ? W'(-lo_n) : lo_n;
    r_fix    = neg_r ? W'(-hi_n) : hi_n;
    if (is_div) result_c = sel_hi ? r_fix : q_fix;
    else        result_c = sel_hi ? prod_fix[2*W-1:W] : prod_fix[W-1:0];
    done_c = active & (cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      is_div <= 1'b0;
      sel_hi <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
    end else if (abort) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      is_div <= func[2];
      sel_hi <= func[2] ? func[1] : (func[1:0] != 2'b00);
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      cnt    <= CW'(DATA_WIDTH);
      hi     <= '0;
      lo     <= func[2] ? a_mag : b_mag;
      m      <= func[2] ? b_mag : a_mag;
    end else if (active) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) active <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with RV32M mul/div: single-cycle base ops, iterative long ops, valid/ready both sides.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 5,
  parameter int unsigned IMM_WIDTH     = 12
) (
  input logic       clk,
  input logic       rst_n,
  alu_mdu_if.slave  bus
);
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                 state;
  logic                   out_valid_q, busy_q;
  logic [DATA_WIDTH-1:0]  result_q;

  logic [DATA_WIDTH-1:0]  a, b, base_res, iter_res_c;
  logic signed [IMM_WIDTH-1:0] imm;
  logic [SHW-1:0]         shamt;
  logic [31:0]            op_ext;
  alu_op_e                op;
  logic                   op_known, md, div_zero, div_ovf, go_iter, accept, in_ready_c;
  logic                   iter_done_c;

  always_comb begin
    op_ext   = 32'(bus.Operation);
    op       = alu_op_e'(op_ext[4:0]);
    op_known = (op_ext[31:5] == 27'd0);
    md       = op_known & is_muldiv(op_ext[4:0]);
    imm      = bus.SrcB[IMM_WIDTH-1:0];
    a        = bus.SrcA;
    b        = bus.isImmediate ? DATA_WIDTH'(imm) : bus.SrcB;
    shamt    = b[SHW-1:0];
    div_zero = md & op_ext[2] & (b == '0);
    div_ovf  = md & op_ext[2] & !op_ext[0] & (a == MOST_NEG) & (b == '1);
  end

  // Flush blocks acceptance; DONE accepts in the same cycle its result is taken.
  always_comb begin
    in_ready_c = ((state == IDLE) | ((state == DONE) & bus.out_ready)) & !bus.flush;
    accept     = bus.in_valid & in_ready_c;
    go_iter    = accept & md & !div_zero & !div_ovf;
  end

  // Single-cycle results, including the divide fast path (bit1 of the code selects REM).
  always_comb begin
    base_res = '0;
    if (div_zero) begin
      base_res = op_ext[1] ? a : '1;
    end else if (div_ovf) begin
      base_res = op_ext[1] ? '0 : a;
    end else if (op_known) begin
      case (op)
        OP_AND:   base_res = a & b;
        OP_OR:    base_res = a | b;
        OP_XOR:   base_res = a ^ b;
        OP_ADD:   base_res = a + b;
        OP_SUB:   base_res = a - b;
        OP_SRL:   base_res = a >> shamt;
        OP_SRA:   base_res = DATA_WIDTH'($signed(a) >>> shamt);
        OP_SLL:   base_res = a << shamt;
        OP_EQ:    base_res = DATA_WIDTH'(a == b);
        OP_NE:    base_res = DATA_WIDTH'(a != b);
        OP_SLT:   base_res = DATA_WIDTH'($signed(a) < $signed(b));
        OP_SGE:   base_res = DATA_WIDTH'($signed(a) >= $signed(b));
        OP_PASSA: base_res = a;
        OP_PASSB: base_res = b;
        OP_SLTU:  base_res = DATA_WIDTH'(a < b);
        OP_SGEU:  base_res = DATA_WIDTH'(a >= b);
        default:  base_res = '0;
      endcase
    end
  end

  alu_mdu_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (bus.flush),
    .start    (go_iter),
    .func     (op_ext[2:0]),
    .a        (a),
    .b        (b),
    .done_c   (iter_done_c),
    .result_c (iter_res_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go_iter) begin
            state       <= BUSY;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= base_res;
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (iter_done_c) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= iter_res_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.ALUResult = result_q;
endmodule
